// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers.
//   clk, rst          : clock, synchronous active-high reset
//   start, op, a, b   : launch mult(00)/multu(01)/div(10)/divu(11) on operands a (rs), b (rt)
//   mthi, mtlo, wdata : direct HI/LO writes while idle
//   busy, done        : operation in flight / one-cycle result-ready pulse
//   hi, lo            : architectural HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;
   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dz;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;
   logic               sgn;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     msum;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   assign busy  = state != IDLE;
   assign sgn   = ~op[0];
   assign a_abs = (sgn && a[WIDTH-1]) ? -a : a;
   assign b_abs = (sgn && b[WIDTH-1]) ? -b : b;
   // Multiply: acc = {partial product, remaining multiplier bits}; the extra sum bit is the carry.
   assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_next = {msum, acc[WIDTH-1:1]};
   // Divide: acc = {partial remainder, dividend bits / quotient bits}; trial[WIDTH] is the borrow.
   assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
   assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   assign prod = neg_q ? -acc : acc;
   // Divide by zero leaves the all-ones quotient untouched by sign correction.
   assign quot = dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         opb    <= '0;
         acc    <= '0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  cnt    <= '0;
                  is_div <= op[1];
                  neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= op[1] && sgn && a[WIDTH-1];
                  dz     <= op[1] && (b == '0);
                  opb    <= b_abs;
                  acc    <= {{WIDTH{1'b0}}, a_abs};
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
            end
            FIN: begin
               hi    <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
               lo    <= is_div ? quot : prod[WIDTH-1:0];
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   int          vectors = 0;
   int          miscompares = 0;
   int          busy_c;
   int          done_c;
   int          done_idx;
   int          mode;
   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Launch at a negedge, then watch 40 cycles; index 0 is the cycle after the start edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_c = 0; done_c = 0; done_idx = -1;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_c++;
         if (done) begin done_c++; done_idx = i; end
         if (mode == 1 && i == 10) begin
            chk("hold_hi", hi, 32'h11);
            chk("hold_lo", lo, 32'h22);
            start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd5; mthi = 1'b1; wdata = 32'hDEAD;
         end
         if (mode == 1 && i == 11) begin start = 1'b0; mthi = 1'b0; end
         if (mode == 2 && i == 15) rst = 1'b1;
         if (mode == 2 && i == 16) begin
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_hi", hi, 32'h0);
            chk("rst_lo", lo, 32'h0);
            rst = 1'b0;
         end
         @(negedge clk);
      end
   endtask
   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el);
      launch(o, x, y);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
      chk({tag, "_done_cnt"}, done_c, 32'd1);
      chk({tag, "_done_idx"}, done_idx, 32'd33);
      chk({tag, "_busy_cyc"}, busy_c, 32'd33);
   endtask
   initial begin
      mode = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      rst = 1'b0;
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      chk("mt_hi", hi, 32'h12345678);
      chk("mt_lo", lo, 32'h12345678);
      chk("mt_busy", {31'b0, busy}, 32'd0);
      chk("mt_done", {31'b0, done}, 32'd0);
      run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run("multu_zero", 2'b01, 32'h0, 32'h1234, 32'h0, 32'h0);
      run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run("divu", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE);
      run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      run("divu_dz", 2'b11, 32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 32'hFFFFFFFF);
      run("div_dz", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h11;
      @(negedge clk);
      mthi = 1'b0; wdata = 32'h22;
      @(negedge clk);
      mtlo = 1'b0;
      chk("pre_hi", hi, 32'h11);
      chk("pre_lo", lo, 32'h22);
      mode = 1;
      run("interfere", 2'b00, 32'd3, 32'd4, 32'h0, 32'hC);
      mode = 2;
      launch(2'b00, 32'd3, 32'd4);
      chk("rst_no_done", done_c, 32'd0);
      chk("rst_after_hi", hi, 32'h0);
      chk("rst_after_lo", lo, 32'h0);
      chk("rst_after_busy", {31'b0, busy}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage directly downstream of the instruction decoder.
- Executes mult, multu, div, divu, mthi and mtlo, and supplies HI/LO read data for mfhi/mflo.
- Asserts busy so the pipeline stalls on any HI/LO access while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin the operation selected by op.
- op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled only when start is accepted.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  rs value for mthi/mtlo.
- busy  output  1  operation in progress; decoder stalls mfhi/mflo/mthi/mtlo/start while high.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset:
  - On a clk edge with rst=1: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal operand/accumulator registers cleared.
  - rst has priority over every other input, including mid-operation; any partial result is discarded.
- States: IDLE, RUN, FIN.
- IDLE, start=1:
  - Latch op, capture the absolute values of a/b for signed ops, and record the result signs.
  - Signed mult: product sign = a[31]^b[31].
  - Signed div: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear counter, go to RUN; busy=1 from the next cycle.
- IDLE, start=0:
  - mthi=1 writes HI<=wdata.
  - mtlo=1 writes LO<=wdata.
  - Both may be asserted in the same cycle.
- IDLE, start=1 together with mthi/mtlo: start wins and the moves are ignored.
- RUN:
  - One radix-2 step per cycle for WIDTH cycles (counter 0..WIDTH-1).
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter=WIDTH-1, go to FIN.
- FIN:
  - Apply sign correction and write HI/LO.
  - mult/multu: {HI,LO} = 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - Go to IDLE. done=1 during the cycle after this edge; busy=0 in that same cycle.
- Latency: start sampled at edge N → HI/LO valid and done=1 after edge N+WIDTH+1 (33 cycles at default).
  - busy is high for exactly WIDTH+1 cycles.
- Signed division rounds toward zero; a nonzero remainder takes the sign of the dividend.
- Divide by zero (b=0, div or divu): no trap. Result is HI=a (unmodified dividend) and LO=all ones; latency is unchanged.
- Overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- While busy=1: start, mthi and mtlo are ignored. hi/lo hold their pre-operation values until the FIN edge.
- hi/lo are direct register outputs with no combinational path from inputs.
- done is low at all times other than the single cycle after FIN.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then mthi=1, mtlo=1, wdata=0x12345678 → hi=lo=0x12345678 the next cycle; busy=0 and done=0 throughout.
- mult a=0xFFFFFFFD (-3), b=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses exactly once; busy high for 33 cycles.
- multu a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; also a=0, b=0x1234 → hi=lo=0.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100, b=7 → lo=0x0000000E, hi=0x00000002; div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: divu a=0xCAFEBABE, b=0 → hi=0xCAFEBABE, lo=0xFFFFFFFF after 33 cycles.
- Interference and reset: with HI=0x11, LO=0x22, issue mult 3×4, then assert start and mthi (wdata=0xDEAD) on cycle 10 → both ignored; result hi=0, lo=0xC. Repeat and assert rst at cycle 15 → next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
